mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one fixed-latency memory port between instruction
// fetch and data access. Data has priority; a starvation counter guarantees fetch progress.
module mem_arbiter #(
  parameter int WAIT   = 2,
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] Address_dm,
  input  logic [15:0] Data_dm,
  output logic [15:0] ReadData_dm,
  output logic        d_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_M1  = 4'(WAIT - 1);
  localparam logic [3:0] STARVE_L = 4'(STARVE);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  logic       grant_if;
  logic       is_write;
  logic       data_req;
  logic       any_req;
  logic       take_fetch;

  // Handshake: a requester raises its request and holds it (with address/data stable)
  // until it sees its one-cycle completion pulse; requests are only looked at in IDLE.
  always_comb begin
    data_req   = MemRead | MemWrite;
    any_req    = if_req | data_req;
    take_fetch = if_req && (!data_req || starve_cnt == STARVE_L);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACC;
      ACC:     if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == ACC);
    mem_we    = (state == ACC) && is_write;
    if_valid  = (state == RESP) && grant_if;
    d_done    = (state == RESP) && !grant_if;
    busy      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      starve_cnt  <= 4'd0;
      grant_if    <= 1'b0;
      is_write    <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 16'h0000;
      if_data     <= 16'h0000;
      ReadData_dm <= 16'h0000;
      err         <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt      <= WAIT_M1;
            grant_if <= take_fetch;
            if (take_fetch) begin
              mem_addr   <= if_addr;
              is_write   <= 1'b0;
              starve_cnt <= 4'd0;
            end else begin
              mem_addr  <= Address_dm;
              mem_wdata <= Data_dm;
              // Conflicting read+write resolves to a write and is flagged.
              is_write  <= MemWrite;
              if (MemRead && MemWrite) err <= 1'b1;
              if (!if_req)                     starve_cnt <= 4'd0;
              else if (starve_cnt != STARVE_L) starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ACC: begin
          if (cnt == 4'd0) begin
            if (!is_write) begin
              if (grant_if) if_data     <= mem_rdata;
              else          ReadData_dm <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT=2, STARVE=3): cycle-accurate checks from the
// stimulus thread plus a completion scoreboard fed by an expected-response queue.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Address_dm;
  logic [15:0] Data_dm;
  logic [15:0] ReadData_dm;
  logic        d_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_we;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // {is_fetch, expected data on the completing side}
  logic [16:0] exp_q[$];

  mem_arbiter #(.WAIT(2), .STARVE(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address_dm(Address_dm), .Data_dm(Data_dm),
    .ReadData_dm(ReadData_dm), .d_done(d_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits for a completion pulse, checking the number of cycles it took.
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if_valid || d_done) && n < 20);
    check({name, "_latency"}, 16'(n), 16'(exp_lat));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (if_valid || d_done)) begin
      logic [16:0] e;
      check("pulse_onehot", 16'(if_valid & d_done), 16'h0000);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pulse: got if_valid=%b d_done=%b expected none", if_valid, d_done);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", 16'(if_valid), 16'(e[16]));
        check("resp_data", if_valid ? if_data : ReadData_dm, e[15:0]);
      end
    end
  end

  initial begin
    logic seen;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; MemRead = 1'b0; MemWrite = 1'b0;
    Address_dm = '0; Data_dm = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_en", 16'(mem_en), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_if_data", if_data, 16'h0000);
    check("rst_rdata_dm", ReadData_dm, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // fetch only
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'h01F1;
    exp_q.push_back({1'b1, 16'h01F1});
    @(negedge clk);
    check("f_c1_en", 16'(mem_en), 16'h1);
    check("f_c1_we", 16'(mem_we), 16'h0);
    check("f_c1_addr", mem_addr, 16'h0010);
    check("f_c1_busy", 16'(busy), 16'h1);
    @(negedge clk);
    check("f_c2_en", 16'(mem_en), 16'h1);
    @(negedge clk);
    check("f_c3_valid", 16'(if_valid), 16'h1);
    check("f_c3_en", 16'(mem_en), 16'h0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_c4_busy", 16'(busy), 16'h0);
    check("f_c4_addr_hold", mem_addr, 16'h0010);

    // data read
    MemRead = 1'b1; Address_dm = 16'h0020; mem_rdata = 16'hBEEF;
    exp_q.push_back({1'b0, 16'hBEEF});
    wait_done("rd", 3);
    MemRead = 1'b0;
    @(negedge clk);
    check("rd_if_data_hold", if_data, 16'h01F1);

    // data write leaves ReadData_dm alone
    MemWrite = 1'b1; Address_dm = 16'h0051; Data_dm = 16'h1234; mem_rdata = 16'hDEAD;
    exp_q.push_back({1'b0, 16'hBEEF});
    @(negedge clk);
    check("w_c1_we", 16'(mem_we), 16'h1);
    check("w_c1_wdata", mem_wdata, 16'h1234);
    check("w_c1_addr", mem_addr, 16'h0051);
    @(negedge clk);
    check("w_c2_we", 16'(mem_we), 16'h1);
    @(negedge clk);
    check("w_c3_done", 16'(d_done), 16'h1);
    MemWrite = 1'b0;
    @(negedge clk);
    check("w_c4_wdata_hold", mem_wdata, 16'h1234);
    check("w_c4_we", 16'(mem_we), 16'h0);
    check("w_c4_err", 16'(err), 16'h0);

    // simultaneous fetch and data read: data first
    if_req = 1'b1; if_addr = 16'h0100; MemRead = 1'b1; Address_dm = 16'h0030; mem_rdata = 16'h5A5A;
    exp_q.push_back({1'b0, 16'h5A5A});
    exp_q.push_back({1'b1, 16'h7777});
    @(negedge clk);
    check("pr_c1_addr", mem_addr, 16'h0030);
    @(negedge clk);
    @(negedge clk);
    check("pr_c3_done", 16'(d_done), 16'h1);
    MemRead = 1'b0; mem_rdata = 16'h7777;
    @(negedge clk);
    check("pr_c4_idle", 16'(busy), 16'h0);
    @(negedge clk);
    check("pr_c5_addr", mem_addr, 16'h0100);
    @(negedge clk);
    @(negedge clk);
    check("pr_c7_valid", 16'(if_valid), 16'h1);
    if_req = 1'b0;
    @(negedge clk);

    // starvation: D D D F D
    if_req = 1'b1; if_addr = 16'h0200; MemRead = 1'b1; Address_dm = 16'h0040; mem_rdata = 16'h0C0C;
    exp_q.push_back({1'b0, 16'h0C0C});
    exp_q.push_back({1'b0, 16'h0C0C});
    exp_q.push_back({1'b0, 16'h0C0C});
    exp_q.push_back({1'b1, 16'h0C0C});
    exp_q.push_back({1'b0, 16'h0C0C});
    for (int i = 0; i < 5; i++) wait_done("starve", (i == 0) ? 3 : 4);
    if_req = 1'b0; MemRead = 1'b0;
    @(negedge clk);

    // conflicting read+write
    MemRead = 1'b1; MemWrite = 1'b1; Address_dm = 16'h0099; Data_dm = 16'hA5A5; mem_rdata = 16'hFFFF;
    exp_q.push_back({1'b0, 16'h0C0C});
    @(negedge clk);
    check("cf_c1_we", 16'(mem_we), 16'h1);
    check("cf_c1_err", 16'(err), 16'h1);
    @(negedge clk);
    @(negedge clk);
    check("cf_c3_done", 16'(d_done), 16'h1);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    MemRead = 1'b1; Address_dm = 16'h0011; mem_rdata = 16'h1111;
    exp_q.push_back({1'b0, 16'h1111});
    wait_done("cf_rd", 3);
    MemRead = 1'b0;
    check("cf_err_sticky", 16'(err), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cf_err_cleared", 16'(err), 16'h0);
    check("cf_rdata_cleared", ReadData_dm, 16'h0000);
    @(negedge clk);

    // reset aborts an in-flight fetch
    if_req = 1'b1; if_addr = 16'h0300; mem_rdata = 16'h3333;
    @(negedge clk);
    check("ab_c1_en", 16'(mem_en), 16'h1);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("ab_c2_en", 16'(mem_en), 16'h0);
    check("ab_c2_busy", 16'(busy), 16'h0);
    check("ab_c2_state", 16'(dbg_state), 16'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | if_valid;
    end
    check("ab_no_pulse", 16'(seen), 16'h0);
    check("ab_if_data", if_data, 16'h0000);

    check("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
